mips_fetch_stage: RTL and testbench
===================================

# mips_fetch_stage

Instruction-fetch (IF) stage of the 5-stage pipelined MIPS model, directly upstream of the decode stage. It owns the program counter and issues word reads to a synchronous instruction memory with one-cycle read latency. Returned words are buffered in a 3-entry queue and presented to decode with a valid/ready handshake. It also applies branch/jump redirects from later stages and stops fetching once a HALT instruction (opcode 6'b010001) has been handed to decode.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset; must be word aligned.
- `IMEM_AW`, 10, instruction-memory word-address width (depth 2^IMEM_AW words).
- `clk` in 1: single clock; all state on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `imem_rd_en` out 1: read request this cycle.
- `imem_addr` out IMEM_AW: word address, equal to `pc[IMEM_AW+1:2]`.
- `imem_rdata` in 32: read data, valid the cycle after `imem_rd_en`.
- `redirect_valid` in 1: flush and load a new PC.
- `redirect_pc` in 32: redirect target; bits [1:0] ignored (treated as 0).
- `if_valid` out 1: `if_instr`/`if_pc` hold a fetched instruction.
- `if_instr` out 32: instruction word.
- `if_pc` out 32: byte address of `if_instr`.
- `id_ready` in 1: decode accepts; transfer occurs when `if_valid && id_ready`.
- `halted` out 1: a HALT has been accepted by decode; fetch is stopped.

## Operation
- State machine with three states:
  - FETCH: normal operation.
  - DRAIN: a HALT word has entered the queue. No new issues are made; the queue drains.
  - HALTED: terminal until reset. No issues; `if_valid`=0; `halted`=1.
- Issue rule in FETCH: `imem_rd_en`=1 iff `!redirect_valid && (occupancy + inflight) < 3`.
  - `inflight` is 0 or 1.
  - `pc` advances by 4 on each issue. The PC value is carried with the request so that `if_pc` matches the word.
- Response:
  - The cycle after an issue, `imem_rdata` and its PC are pushed into the queue, unless squashed.
  - A word whose opcode is 6'b010001 moves FETCH to DRAIN.
- Queue:
  - 3 entries, with read/write pointers wrapping modulo 3.
  - Push and pop in the same cycle are both honoured.
  - Overflow is impossible by the credit rule. Reaching it anyway is an internal error.
- Redirect, highest priority:
  - The queue is cleared, any inflight response is marked squashed (dropped on arrival), and `pc` is loaded from `{redirect_pc[31:2],2'b00}`.
  - The state returns to FETCH from FETCH or DRAIN.
  - A handshake coinciding with redirect is void; decode is flushing too.
  - Ignored in HALTED.
- Acceptance of the HALT entry (DRAIN, `if_valid && id_ready`, no redirect) moves to HALTED.
- Address wrap: `imem_addr` wraps modulo 2^IMEM_AW. `pc` is a full 32-bit value and wraps at 2^32.

## Timing
- Reset values:
  - `pc`=RESET_PC, state=FETCH, queue empty, inflight=0.
  - Outputs: `imem_rd_en`=0, `imem_addr`=0, `if_valid`=0, `if_instr`=0, `if_pc`=0, `halted`=0.
- Outputs are driven from registers/queue head. `imem_rd_en` and `imem_addr` are combinational from state, `pc` and counts.
- Latency from reset release:
  - First issue in cycle 1.
  - Data captured at the end of cycle 2.
  - `if_valid`=1 from cycle 3.
- Throughput: one instruction per cycle while `id_ready`=1.
- With `id_ready`=0, at most 3 words accumulate and issue stops. No word is lost or duplicated.
- Redirect in cycle R:
  - No issue in R.
  - Issue at the target in R+1.
  - `if_valid`=0 in R+1 and R+2.
  - Target word visible in R+3.
- Simultaneous HALT acceptance and redirect: the redirect wins and `halted` stays 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). A response in flight at reset is discarded.

## Configuration
- `MIPS_FETCH_TRACE_EN`:
  - Defined: on every accepted transfer, print a simulation-only message `IF: pc=%08h instr=%08h`; print `IF: HALT at pc=%08h` on entry to HALTED.
  - Undefined: no display code; RTL is identical in behaviour.

## Structure
- Shared `mips_pkg` additions:
  - `localparam OP_HALT = 6'b010001`.
  - `localparam INSTR_W = 32`.
  - `typedef struct packed {logic [31:0] pc; logic [31:0] instr;} if_id_t`.
  - `typedef enum logic [1:0] {IF_FETCH, IF_DRAIN, IF_HALTED} if_state_e`.
- Sub-module `mips_fetch_queue`:
  - 3-entry `if_id_t` FIFO with push, pop, flush, occupancy and head outputs.
  - Same clock and asynchronous active-high reset.

## Test plan
- Reset, memory words 0..7 = 32'h0000_0001+i, `id_ready`=1 → `if_valid` from cycle 3; `if_pc`=0,4,8,… on consecutive cycles; `if_instr` matches memory.
- `id_ready`=0 for cycles 5–9, then 1 → `imem_rd_en` drops after 3 buffered words; the stream resumes in order with no gap in PCs and no duplicates.
- `redirect_valid`=1 with `redirect_pc`=32'h0000_0043 in cycle 6 → squashed response is dropped; `if_valid`=0 in cycles 7–8; cycle 9 shows `if_pc`=32'h0000_0040.
- Word at PC 0x10 = 32'h4400_0000 (HALT) → no issue past PC 0x10+8; after acceptance `halted`=1, `if_valid`=0, and a later redirect is ignored.
- HALT in queue plus redirect to 0x100 in the same cycle it is accepted → `halted`=0, fetch restarts at 0x100.
- RESET_PC=32'h0000_0FF8, IMEM_AW=10 → `imem_addr`=1022, 1023, 0, 1; `if_pc`=0xFF8, 0xFFC, 0x1000. Pulse `rst` mid-stream → all outputs return to reset values at once.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants.
package mips_pkg;

  localparam int         INSTR_W = 32;
  localparam logic [5:0] OP_HALT = 6'b010001;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef enum logic [1:0] {IF_FETCH, IF_DRAIN, IF_HALTED} if_state_e;

  // Pointer increment for a 3-deep ring.
  function automatic logic [1:0] ptr_inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/mips_fetch_queue.sv
// Three-entry FIFO of fetched {pc, instr} pairs between the IF stage and decode.
module mips_fetch_queue
  import mips_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  if_id_t     push_data_i,
  input  logic       pop_i,
  input  logic       flush_i,
  output logic [1:0] count_o,
  output if_id_t     head_o
);

  if_id_t     mem_q [3];
  logic [1:0] wr_ptr_q, rd_ptr_q, count_q;
  logic       do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  // The fetch credit rule keeps a full queue from seeing a lone push; drop it if it ever does.
  assign do_push = push_i && ((count_q != 2'd3) || do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ptr_inc3(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc3(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, credit-limited imem issue, 3-deep queue, redirect and HALT handling.
// Optional MIPS_FETCH_TRACE_EN adds simulation-only transfer/HALT messages.
module mips_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_rd_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  input  logic               id_ready,
  output logic               halted
);

  if_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d;
  logic        inflight_q, run_q;
  logic        issue, push, pop, flush;
  logic [1:0]  q_count;
  logic [2:0]  credits_used;
  logic [31:0] redirect_target;
  if_id_t      q_head;

  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign credits_used    = {1'b0, q_count} + {2'b00, inflight_q};

  // run_q holds issue off for the first cycle after reset so outputs read as reset values.
  assign issue      = run_q && (state_q == IF_FETCH) && !redirect_valid && (credits_used < 3'd3);
  assign imem_rd_en = issue;
  assign imem_addr  = run_q ? pc_q[IMEM_AW+1:2] : '0;

  assign flush    = redirect_valid && (state_q != IF_HALTED);
  assign push     = inflight_q && (state_q == IF_FETCH) && !redirect_valid;
  assign if_valid = (state_q != IF_HALTED) && (q_count != 2'd0);
  assign pop      = if_valid && id_ready && !redirect_valid;
  assign if_instr = q_head.instr;
  assign if_pc    = q_head.pc;
  assign halted   = (state_q == IF_HALTED);

  mips_fetch_queue u_queue (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i ({req_pc_q, imem_rdata}),
    .pop_i       (pop),
    .flush_i     (flush),
    .count_o     (q_count),
    .head_o      (q_head)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = issue ? pc_q + 32'd4 : pc_q;
    req_pc_d = issue ? pc_q : req_pc_q;
    case (state_q)
      IF_FETCH:  if (push && (imem_rdata[31:26] == OP_HALT)) state_d = IF_DRAIN;
      // Words arriving after the HALT are not pushed, so a HALT head in DRAIN is the HALT itself.
      IF_DRAIN:  if (pop && (q_head.instr[31:26] == OP_HALT)) state_d = IF_HALTED;
      default:   state_d = state_q;
    endcase
    if (flush) begin
      state_d = IF_FETCH;
      pc_d    = redirect_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IF_FETCH;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= issue;
      run_q      <= 1'b1;
    end
  end

`ifdef MIPS_FETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && pop) $display("IF: pc=%08h instr=%08h", if_pc, if_instr);
    if (!rst && (state_q != IF_HALTED) && (state_d == IF_HALTED))
      $display("IF: HALT at pc=%08h", if_pc);
  end
`else
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed table-driven bench for mips_fetch_stage plus a wrap/async-reset sequence on a second instance.
module tb_mips_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] HALT_W = 32'h4400_0000;

  logic        rst, imem_rd_en, redirect_valid, if_valid, id_ready, halted;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata, redirect_pc, if_instr, if_pc;

  logic        rst_h, imem_rd_en_h, redirect_valid_h, if_valid_h, id_ready_h, halted_h;
  logic [9:0]  imem_addr_h;
  logic [31:0] imem_rdata_h, redirect_pc_h, if_instr_h, if_pc_h;

  mips_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) u_dut (
    .clk(clk), .rst(rst), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .halted(halted)
  );

  mips_fetch_stage #(.RESET_PC(32'h0000_0FF8), .IMEM_AW(10)) u_dut_h (
    .clk(clk), .rst(rst_h), .imem_rd_en(imem_rd_en_h), .imem_addr(imem_addr_h),
    .imem_rdata(imem_rdata_h), .redirect_valid(redirect_valid_h), .redirect_pc(redirect_pc_h),
    .if_valid(if_valid_h), .if_instr(if_instr_h), .if_pc(if_pc_h), .id_ready(id_ready_h),
    .halted(halted_h)
  );

  logic [31:0] mem   [1024];
  logic [31:0] mem_h [1024];

  always @(posedge clk) if (imem_rd_en)   imem_rdata   <= mem[imem_addr];
  always @(posedge clk) if (imem_rd_en_h) imem_rdata_h <= mem_h[imem_addr_h];

  typedef struct {
    bit          reset_first;
    bit          halt4;
    int          scen;
    int          cyc;
    logic        rdv;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_rd;
    logic [9:0]  e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_halt;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   fill_scen = 0;
  int   fill_cyc  = 0;
  bit   fill_rst  = 0;
  bit   fill_h4   = 0;

  task automatic chk(input string name, input int s, input int c,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s scen %0d cycle %0d: got %h expected %h", name, s, c, act, exp);
    end
  endtask

  task automatic start(input int s, input bit h4);
    fill_scen = s;
    fill_cyc  = 0;
    fill_rst  = 1;
    fill_h4   = h4;
  endtask

  task automatic r(input logic rdv, input logic [31:0] rpc, input logic rdy,
                   input logic erd, input logic [9:0] ea, input logic ev,
                   input logic [31:0] epc, input logic [31:0] ei, input logic eh);
    vec_t v;
    v.reset_first = fill_rst;
    v.halt4 = fill_h4;
    v.scen = fill_scen;
    v.cyc = fill_cyc;
    v.rdv = rdv; v.rpc = rpc; v.rdy = rdy;
    v.e_rd = erd; v.e_addr = ea; v.e_v = ev; v.e_pc = epc; v.e_instr = ei; v.e_halt = eh;
    vecs.push_back(v);
    fill_rst = 0;
    fill_cyc++;
  endtask

  // Cycles 0..4 after reset release with id_ready=1 and no redirect.
  task automatic prefix();
    r(0, 0, 1, 0, 0, 0, 0, 0, 0);
    r(0, 0, 1, 1, 0, 0, 0, 0, 0);
    r(0, 0, 1, 1, 1, 0, 0, 0, 0);
    r(0, 0, 1, 1, 2, 1, 32'h0, 32'h1, 0);
    r(0, 0, 1, 1, 3, 1, 32'h4, 32'h2, 0);
  endtask

  task automatic hrow(input int c, input logic erd, input logic [9:0] ea, input logic ev,
                      input logic [31:0] epc, input logic [31:0] ei);
    #1;
    chk("wrap_rd_en", 9, c, {31'b0, imem_rd_en_h}, {31'b0, erd});
    chk("wrap_addr", 9, c, {22'b0, imem_addr_h}, {22'b0, ea});
    chk("wrap_valid", 9, c, {31'b0, if_valid_h}, {31'b0, ev});
    if (ev) begin
      chk("wrap_pc", 9, c, if_pc_h, epc);
      chk("wrap_instr", 9, c, if_instr_h, ei);
    end
    @(negedge clk);
  endtask

  task automatic h_reset_check(input int c);
    chk("rst_rd_en", 9, c, {31'b0, imem_rd_en_h}, 32'h0);
    chk("rst_addr", 9, c, {22'b0, imem_addr_h}, 32'h0);
    chk("rst_valid", 9, c, {31'b0, if_valid_h}, 32'h0);
    chk("rst_pc", 9, c, if_pc_h, 32'h0);
    chk("rst_instr", 9, c, if_instr_h, 32'h0);
    chk("rst_halted", 9, c, {31'b0, halted_h}, 32'h0);
  endtask

  initial begin
    rst = 1; rst_h = 1;
    redirect_valid = 0; redirect_pc = 0; id_ready = 1;
    redirect_valid_h = 0; redirect_pc_h = 0; id_ready_h = 1;
    for (int i = 0; i < 1024; i++) begin
      mem[i]   = 32'h0000_0001 + i;
      mem_h[i] = 32'h0000_0001 + i;
    end

    // Scenario 0: streaming with a decode stall in cycles 5..9.
    start(0, 0);
    prefix();
    r(0, 0, 0, 1, 4, 1, 32'h8, 32'h3, 0);
    r(0, 0, 0, 0, 5, 1, 32'h8, 32'h3, 0);
    r(0, 0, 0, 0, 5, 1, 32'h8, 32'h3, 0);
    r(0, 0, 0, 0, 5, 1, 32'h8, 32'h3, 0);
    r(0, 0, 0, 0, 5, 1, 32'h8, 32'h3, 0);
    r(0, 0, 1, 0, 5, 1, 32'h8, 32'h3, 0);
    r(0, 0, 1, 1, 5, 1, 32'hC, 32'h4, 0);
    r(0, 0, 1, 1, 6, 1, 32'h10, 32'h5, 0);
    r(0, 0, 1, 1, 7, 1, 32'h14, 32'h6, 0);
    r(0, 0, 1, 1, 8, 1, 32'h18, 32'h7, 0);
    r(0, 0, 1, 1, 9, 1, 32'h1C, 32'h8, 0);

    // Scenario 1: redirect to 0x43 in cycle 6.
    start(1, 0);
    prefix();
    r(0, 0, 1, 1, 4, 1, 32'h8, 32'h3, 0);
    r(1, 32'h43, 1, 0, 5, 1, 32'hC, 32'h4, 0);
    r(0, 0, 1, 1, 16, 0, 0, 0, 0);
    r(0, 0, 1, 1, 17, 0, 0, 0, 0);
    r(0, 0, 1, 1, 18, 1, 32'h40, 32'h11, 0);
    r(0, 0, 1, 1, 19, 1, 32'h44, 32'h12, 0);

    // Scenario 2: HALT at 0x10, later redirect ignored.
    start(2, 1);
    prefix();
    r(0, 0, 1, 1, 4, 1, 32'h8, 32'h3, 0);
    r(0, 0, 1, 1, 5, 1, 32'hC, 32'h4, 0);
    r(0, 0, 1, 0, 6, 1, 32'h10, HALT_W, 0);
    r(0, 0, 1, 0, 6, 0, 0, 0, 1);
    r(1, 32'h100, 1, 0, 6, 0, 0, 0, 1);
    r(0, 0, 1, 0, 6, 0, 0, 0, 1);

    // Scenario 3: redirect to 0x100 in the cycle the HALT is accepted.
    start(3, 1);
    prefix();
    r(0, 0, 1, 1, 4, 1, 32'h8, 32'h3, 0);
    r(0, 0, 1, 1, 5, 1, 32'hC, 32'h4, 0);
    r(1, 32'h100, 1, 0, 6, 1, 32'h10, HALT_W, 0);
    r(0, 0, 1, 1, 64, 0, 0, 0, 0);
    r(0, 0, 1, 1, 65, 0, 0, 0, 0);
    r(0, 0, 1, 1, 66, 1, 32'h100, 32'h41, 0);
    r(0, 0, 1, 1, 67, 1, 32'h104, 32'h42, 0);

    @(negedge clk);
    foreach (vecs[i]) begin
      if (vecs[i].reset_first) begin
        rst = 1;
        redirect_valid = 0;
        id_ready = 1;
        mem[4] = vecs[i].halt4 ? HALT_W : 32'h0000_0005;
        repeat (2) @(negedge clk);
        rst = 0;
      end
      redirect_valid = vecs[i].rdv;
      redirect_pc    = vecs[i].rpc;
      id_ready       = vecs[i].rdy;
      #1;
      chk("rd_en", vecs[i].scen, vecs[i].cyc, {31'b0, imem_rd_en}, {31'b0, vecs[i].e_rd});
      chk("addr", vecs[i].scen, vecs[i].cyc, {22'b0, imem_addr}, {22'b0, vecs[i].e_addr});
      chk("valid", vecs[i].scen, vecs[i].cyc, {31'b0, if_valid}, {31'b0, vecs[i].e_v});
      chk("halted", vecs[i].scen, vecs[i].cyc, {31'b0, halted}, {31'b0, vecs[i].e_halt});
      if (vecs[i].e_v) begin
        chk("if_pc", vecs[i].scen, vecs[i].cyc, if_pc, vecs[i].e_pc);
        chk("if_instr", vecs[i].scen, vecs[i].cyc, if_instr, vecs[i].e_instr);
      end
      @(negedge clk);
    end
    rst = 1;
    redirect_valid = 0;

    // Address wrap from RESET_PC=0xFF8, then an asynchronous reset mid-stream.
    rst_h = 0;
    hrow(0, 0, 0,    0, 0, 0);
    hrow(1, 1, 1022, 0, 0, 0);
    hrow(2, 1, 1023, 0, 0, 0);
    hrow(3, 1, 0,    1, 32'h0000_0FF8, 32'h0000_03FF);
    hrow(4, 1, 1,    1, 32'h0000_0FFC, 32'h0000_0400);
    hrow(5, 1, 2,    1, 32'h0000_1000, 32'h0000_0001);
    rst_h = 1;
    #1;
    h_reset_check(6);
    @(negedge clk);
    rst_h = 0;
    hrow(10, 0, 0,    0, 0, 0);
    hrow(11, 1, 1022, 0, 0, 0);
    hrow(12, 1, 1023, 0, 0, 0);
    hrow(13, 1, 0,    1, 32'h0000_0FF8, 32'h0000_03FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
